// File: rtl/usb_tx_serializer_if.sv
// Handshake bundle for usb_tx_serializer: packet request,
// payload stream and serial bit output.
interface usb_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bit_en;
    logic                  pkt_start;
    logic [3:0]            pkt_pid;
    logic                  pkt_has_data;
    logic                  pkt_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic                  ser_out;
    logic                  ser_val;
    logic                  ser_last;
    logic                  ser_stuff;
    logic                  ser_busy;
    logic                  ser_underrun;

    modport master (
        output bit_en, pkt_start, pkt_pid, pkt_has_data,
        output s_data, s_valid, s_last,
        input  pkt_ready, s_ready,
        input  ser_out, ser_val, ser_last, ser_stuff,
        input  ser_busy, ser_underrun
    );

    modport slave (
        input  bit_en, pkt_start, pkt_pid, pkt_has_data,
        input  s_data, s_valid, s_last,
        output pkt_ready, s_ready,
        output ser_out, ser_val, ser_last, ser_stuff,
        output ser_busy, ser_underrun
    );
endinterface

// File: rtl/usb_tx_serializer.sv
// USB TX packet serializer: SYNC, PID, queued payload, LSB-first.
// Define USB_TX_BITSTUFF_EN to insert a 0 after six consecutive 1s.
module usb_tx_serializer #(
    parameter int         DATA_WIDTH   = 8,
    parameter int         QUEUE_DEPTH  = 4,
    parameter logic [7:0] SYNC_PATTERN = 8'h80
) (
    input logic                clk,
    input logic                rst_n,
    usb_tx_serializer_if.slave bus
);
`ifdef USB_TX_BITSTUFF_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif
    localparam int MAXW = (DATA_WIDTH > 8) ? DATA_WIDTH : 8;
    localparam int BCW  = $clog2(MAXW);
    localparam int DIW  = $clog2(DATA_WIDTH);
    localparam int PW   = $clog2(QUEUE_DEPTH);
    localparam int CW   = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, SYNC, PID, PAYLOAD} state_t;

    state_t                state;
    logic [3:0]            pid;
    logic                  has_data;
    logic [BCW-1:0]        bit_cnt;
    logic [2:0]            ones;
    logic                  fin;
    logic [DATA_WIDTH-1:0] cur_word;
    logic                  cur_last;

    logic [DATA_WIDTH:0]   mem [QUEUE_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic [DATA_WIDTH:0]   head;

    logic push, pop, underrun, stuff_due, stuff_next;
    logic field_end, pkt_done, cur_bit;
    logic [7:0] pid_byte;
    logic [PW-1:0] wr_idx;

    assign head      = mem[rd_ptr];
    assign pid_byte  = {~pid, pid};
    assign bus.pkt_ready = (state == IDLE);
    assign bus.s_ready   = (count != CW'(QUEUE_DEPTH));
    assign push      = bus.s_valid && bus.s_ready;
    assign stuff_due = STUFF_EN && (ones == 3'd6);
    assign underrun  = bus.bit_en && (state == PAYLOAD) && !stuff_due
                       && (bit_cnt == '0) && (count == '0);
    assign pop       = bus.bit_en && (state == PAYLOAD) && !stuff_due
                       && (bit_cnt == '0) && (count != '0);
    assign wr_idx    = underrun ? '0 : wr_ptr;

    always_comb begin
        cur_bit   = 1'b0;
        field_end = 1'b0;
        pkt_done  = 1'b0;
        case (state)
            SYNC: begin
                cur_bit   = SYNC_PATTERN[bit_cnt[2:0]];
                field_end = (bit_cnt == BCW'(7));
            end
            PID: begin
                cur_bit   = pid_byte[bit_cnt[2:0]];
                field_end = (bit_cnt == BCW'(7));
                pkt_done  = !has_data;
            end
            PAYLOAD: begin
                cur_bit   = (bit_cnt == '0) ? head[0]
                                            : cur_word[bit_cnt[DIW-1:0]];
                field_end = (bit_cnt == BCW'(DATA_WIDTH - 1));
                pkt_done  = cur_last;
            end
            default: ;
        endcase
    end

    // A final data bit that completes six 1s defers ser_last to the stuff bit
    assign stuff_next = STUFF_EN && cur_bit && (ones == 3'd5);

    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= {bus.s_last, bus.s_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (underrun) begin
            rd_ptr <= '0;
            wr_ptr <= PW'(push);
            count  <= CW'(push);
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            pid              <= '0;
            has_data         <= 1'b0;
            bit_cnt          <= '0;
            ones             <= '0;
            fin              <= 1'b0;
            cur_word         <= '0;
            cur_last         <= 1'b0;
            bus.ser_out      <= 1'b0;
            bus.ser_val      <= 1'b0;
            bus.ser_last     <= 1'b0;
            bus.ser_stuff    <= 1'b0;
            bus.ser_busy     <= 1'b0;
            bus.ser_underrun <= 1'b0;
        end else begin
            bus.ser_out      <= 1'b0;
            bus.ser_val      <= 1'b0;
            bus.ser_last     <= 1'b0;
            bus.ser_stuff    <= 1'b0;
            bus.ser_underrun <= 1'b0;
            if (state == IDLE) begin
                if (bus.pkt_start) begin
                    state        <= SYNC;
                    pid          <= bus.pkt_pid;
                    has_data     <= bus.pkt_has_data;
                    bit_cnt      <= '0;
                    ones         <= '0;
                    fin          <= 1'b0;
                    bus.ser_busy <= 1'b1;
                end
            end else if (bus.bit_en) begin
                if (stuff_due) begin
                    bus.ser_val   <= 1'b1;
                    bus.ser_stuff <= 1'b1;
                    ones          <= '0;
                    if (fin) begin
                        fin          <= 1'b0;
                        bus.ser_last <= 1'b1;
                        bus.ser_busy <= 1'b0;
                        state        <= IDLE;
                    end
                end else if (underrun) begin
                    bus.ser_underrun <= 1'b1;
                    bus.ser_busy     <= 1'b0;
                    state            <= IDLE;
                end else begin
                    bus.ser_val <= 1'b1;
                    bus.ser_out <= cur_bit;
                    if (STUFF_EN && state != SYNC)
                        ones <= cur_bit ? ones + 3'd1 : 3'd0;
                    if (pop) begin
                        cur_word <= head[DATA_WIDTH-1:0];
                        cur_last <= head[DATA_WIDTH];
                    end
                    if (!field_end) begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end else begin
                        bit_cnt <= '0;
                        if (pkt_done) begin
                            if (stuff_next) begin
                                fin <= 1'b1;
                            end else begin
                                bus.ser_last <= 1'b1;
                                bus.ser_busy <= 1'b0;
                                state        <= IDLE;
                            end
                        end else if (state == SYNC) begin
                            state <= PID;
                        end else if (state == PID) begin
                            state <= PAYLOAD;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_usb_tx_serializer.sv
// Directed scoreboard bench for usb_tx_serializer.
// Honours USB_TX_BITSTUFF_EN in its expected bit model.
module tb_usb_tx_serializer;
`ifdef USB_TX_BITSTUFF_EN
    localparam bit STUFF = 1'b1;
`else
    localparam bit STUFF = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic l;
        logic s;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   pulses = 0;
    int   lasts = 0;
    int   stuff_pos = 0;
    int   prev_cyc = -1;
    bit   throttle = 1'b0;
    bit   chk_space = 1'b0;
    exp_t sb[$];
    exp_t e;

    usb_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

    usb_tx_serializer #(
        .DATA_WIDTH  (8),
        .QUEUE_DEPTH (4),
        .SYNC_PATTERN(8'h80)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        bus.bit_en = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.bit_en = throttle ? (cyc % 4 == 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.ser_val) begin
                pulses++;
                if (bus.ser_last) lasts++;
                if (bus.ser_stuff) stuff_pos = pulses;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $error("FAIL extra_bit: pulse %0d with no expected bit", pulses);
                end else begin
                    e = sb.pop_front();
                    assert ({bus.ser_out, bus.ser_last, bus.ser_stuff} === e)
                    else begin
                        errors++;
                        $error("FAIL bit%0d: got %b expected %b", pulses,
                               {bus.ser_out, bus.ser_last, bus.ser_stuff}, e);
                    end
                end
                if (chk_space && prev_cyc >= 0) begin
                    checks++;
                    assert (cyc - prev_cyc == 4)
                    else begin
                        errors++;
                        $error("FAIL spacing: got %0d expected 4", cyc - prev_cyc);
                    end
                end
                prev_cyc = cyc;
            end else begin
                checks++;
                assert ({bus.ser_out, bus.ser_last, bus.ser_stuff} === 3'b000)
                else begin
                    errors++;
                    $error("FAIL idle_out: got %b expected 000",
                           {bus.ser_out, bus.ser_last, bus.ser_stuff});
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(input logic [3:0] pid, input int nw,
                           input logic [31:0] words, input bit with_last);
        exp_t q[$];
        exp_t t;
        logic [7:0] sp;
        logic [7:0] pb;
        logic b;
        int ones;
        sp = 8'h80;
        pb = {~pid, pid};
        ones = 0;
        for (int i = 0; i < 8; i++) q.push_back({sp[i], 2'b00});
        for (int i = 0; i < 8 + 8 * nw; i++) begin
            b = (i < 8) ? pb[i] : words[i-8];
            q.push_back({b, 2'b00});
            ones = b ? ones + 1 : 0;
            if (STUFF && ones == 6) begin
                q.push_back(3'b001);
                ones = 0;
            end
        end
        if (with_last) begin
            t = q.pop_back();
            t.l = 1'b1;
            q.push_back(t);
        end
        foreach (q[k]) sb.push_back(q[k]);
        pulses = 0;
        lasts = 0;
        stuff_pos = 0;
        prev_cyc = -1;
    endtask

    task automatic push_word(input logic [7:0] d, input bit last);
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        step();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic start_pkt(input logic [3:0] pid, input bit hd);
        chk("pkt_ready_idle", bus.pkt_ready, 1);
        bus.pkt_start    = 1'b1;
        bus.pkt_pid      = pid;
        bus.pkt_has_data = hd;
        step();
        bus.pkt_start = 1'b0;
        chk("busy_after_start", bus.ser_busy, 1);
    endtask

    task automatic wait_end(input string tag, input int max);
        int n;
        n = 0;
        while (bus.ser_last !== 1'b1 && bus.ser_underrun !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        checks++;
        assert (n < max)
        else begin
            errors++;
            $error("FAIL %s_timeout: got %0d cycles expected < %0d", tag, n, max);
        end
        #1;
    endtask

    initial begin
        bus.pkt_start    = 1'b0;
        bus.pkt_pid      = 4'h0;
        bus.pkt_has_data = 1'b0;
        bus.s_data       = 8'h00;
        bus.s_valid      = 1'b0;
        bus.s_last       = 1'b0;
        #1;
        chk("rst_outs", {bus.ser_out, bus.ser_val, bus.ser_last, bus.ser_stuff,
                         bus.ser_busy, bus.ser_underrun}, 0);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_pkt_ready", bus.pkt_ready, 1);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // ACK handshake
        exp_pkt(4'b0010, 0, 32'h0, 1'b1);
        start_pkt(4'b0010, 1'b0);
        wait_end("ack", 100);
        chk("ack_busy_at_last", bus.ser_busy, 0);
        chk("ack_pulses", pulses, 16);
        chk("ack_lasts", lasts, 1);
        chk("ack_sb_empty", sb.size(), 0);
        @(negedge clk);
        chk("ack_pkt_ready", bus.pkt_ready, 1);
        step();

        // DATA0 with preloaded payload and an ignored mid-packet request
        push_word(8'hA5, 1'b0);
        push_word(8'h3C, 1'b1);
        exp_pkt(4'b0011, 2, 32'h3CA5, 1'b1);
        start_pkt(4'b0011, 1'b1);
        repeat (5) step();
        bus.pkt_start = 1'b1;
        step();
        bus.pkt_start = 1'b0;
        wait_end("data0", 100);
        chk("data0_pulses", pulses, 32);
        chk("data0_lasts", lasts, 1);
        chk("data0_sb_empty", sb.size(), 0);
        repeat (40) step();
        chk("data0_no_repeat", pulses, 32);
        chk("data0_idle_busy", bus.ser_busy, 0);

        // DATA1 all-ones payload exercises stuffing
        push_word(8'hFF, 1'b1);
        exp_pkt(4'b1011, 1, 32'hFF, 1'b1);
        start_pkt(4'b1011, 1'b1);
        wait_end("data1", 100);
        chk("data1_pulses", pulses, STUFF ? 25 : 24);
        chk("data1_stuff_pos", stuff_pos, STUFF ? 23 : 0);
        chk("data1_lasts", lasts, 1);
        chk("data1_sb_empty", sb.size(), 0);
        step();

        // Backpressure: 4 words fill the queue, a 5th is refused
        push_word(8'hA1, 1'b0);
        push_word(8'hB2, 1'b0);
        push_word(8'hC3, 1'b0);
        push_word(8'hD4, 1'b1);
        chk("full_s_ready", bus.s_ready, 0);
        push_word(8'hEE, 1'b1);
        chk("full_still", bus.s_ready, 0);
        exp_pkt(4'b0011, 4, 32'hD4C3B2A1, 1'b1);
        start_pkt(4'b0011, 1'b1);
        wait_end("full", 200);
        chk("full_pulses", pulses, 48);
        chk("full_sb_empty", sb.size(), 0);
        chk("drained_s_ready", bus.s_ready, 1);
        step();

        // Underrun: refused 5th word must not be present
        exp_pkt(4'b0011, 0, 32'h0, 1'b0);
        start_pkt(4'b0011, 1'b1);
        wait_end("underrun", 100);
        chk("ur_pulse", bus.ser_underrun, 1);
        chk("ur_pulses", pulses, 16);
        chk("ur_lasts", lasts, 0);
        chk("ur_busy", bus.ser_busy, 0);
        chk("ur_sb_empty", sb.size(), 0);
        step();
        chk("ur_pulse_one_cycle", bus.ser_underrun, 0);

        // Throttled bit strobe
        throttle = 1'b1;
        repeat (4) step();
        exp_pkt(4'b0010, 0, 32'h0, 1'b1);
        chk_space = 1'b1;
        start_pkt(4'b0010, 1'b0);
        wait_end("throttle", 200);
        chk_space = 1'b0;
        chk("thr_pulses", pulses, 16);
        chk("thr_sb_empty", sb.size(), 0);
        throttle = 1'b0;
        repeat (2) step();

        // Reset in the middle of the payload
        push_word(8'hA5, 1'b0);
        push_word(8'h3C, 1'b1);
        exp_pkt(4'b0011, 2, 32'h3CA5, 1'b1);
        start_pkt(4'b0011, 1'b1);
        for (int n = 0; n < 200 && pulses < 20; n++) @(negedge clk);
        chk("mid_reached", pulses >= 20, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {bus.ser_out, bus.ser_val, bus.ser_last, bus.ser_stuff,
                             bus.ser_busy, bus.ser_underrun}, 0);
        chk("mid_rst_s_ready", bus.s_ready, 1);
        chk("mid_rst_pkt_ready", bus.pkt_ready, 1);
        sb.delete();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        exp_pkt(4'b0010, 0, 32'h0, 1'b1);
        start_pkt(4'b0010, 1'b0);
        wait_end("post_rst", 100);
        chk("post_rst_pulses", pulses, 16);
        chk("post_rst_lasts", lasts, 1);
        chk("post_rst_sb_empty", sb.size(), 0);
        repeat (3) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/usb_tx_serializer.md
# usb_tx_serializer

Parametrised packet serializer for the USB hub transmit path. It accepts a packet request (PID plus an optional payload) and an AXI-style stream of payload words through an internal queue. It emits SYNC, the PID byte and the payload LSB-first, one bit per `bit_en` strobe, for the downstream NRZI/line driver. It generalises the hub's single-byte PISO with arbitrary PID framing, a configurable payload queue depth, a bit-rate strobe, underrun detection and optional bit stuffing.

## Interface
- `DATA_WIDTH`, 8: payload word width in bits; must be ≥ 4.
- `QUEUE_DEPTH`, 4: payload queue depth in words; power of 2, ≥ 2.
- `SYNC_PATTERN`, 8'h80: SYNC field, sent LSB-first; always 8 bits.
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_en`  in  1  bit-rate strobe; each high cycle in an active state emits one bit.
- `pkt_start`  in  1  packet request; accepted when `pkt_ready`=1.
- `pkt_pid`  in  4  PID nibble; the transmitted PID byte is {~pid, pid}.
- `pkt_has_data`  in  1  1 = payload follows PID; 0 = token/handshake only.
- `pkt_ready`  out  1  1 in IDLE (combinational).
- `s_data`  in  DATA_WIDTH  payload word.
- `s_valid`  in  1  payload word valid.
- `s_last`  in  1  final word of the packet payload.
- `s_ready`  out  1  queue not full (combinational from the registered count).
- `ser_out`  out  1  serial bit.
- `ser_val`  out  1  one-cycle pulse; `ser_out` is valid.
- `ser_last`  out  1  qualifies the final bit of the packet.
- `ser_stuff`  out  1  the current bit is a stuffed 0.
- `ser_busy`  out  1  FSM not in IDLE.
- `ser_underrun`  out  1  one-cycle pulse; payload queue empty when a word was needed.

## Operation
- Queue:
  - Circular FIFO of {last, data}; the count is `$clog2(QUEUE_DEPTH+1)` bits wide; pointers wrap modulo `QUEUE_DEPTH`.
  - Push on `s_valid && s_ready`. When full, `s_ready`=0 and a same-cycle pop does not admit a push.
  - Pop when bit 0 of a word is emitted.
- FSM states IDLE, SYNC, PID, PAYLOAD:
  - IDLE→SYNC on `pkt_start`. PID and `pkt_has_data` are captured at that point.
  - SYNC→PID after 8 bits.
  - PID→PAYLOAD after 8 bits if `has_data`; otherwise PID→IDLE.
  - PAYLOAD→IDLE after the last bit of a word popped with last=1.
- Bit order is LSB-first throughout. A bit counter sized for max(8, DATA_WIDTH) resets at each field or word boundary.
- Underrun: at the `bit_en` that would emit bit 0 of a payload word with the queue empty:
  - no bit is emitted and `ser_underrun` pulses;
  - the queue is flushed (count and pointers cleared);
  - FSM→IDLE and `ser_last` is never asserted for that packet.
- `pkt_start` while busy is ignored and is not queued.
- Reset (any time, including mid-packet): asynchronous clear.
  - `ser_out`, `ser_val`, `ser_last`, `ser_stuff`, `ser_busy`, `ser_underrun` = 0.
  - Queue empty, so `s_ready`=1. State IDLE, so `pkt_ready`=1.

## Timing
- `pkt_start` accepted at cycle T: `ser_busy`=1 from T+1. The first `bit_en` at or after T+1 produces SYNC bit 0 on the following cycle.
- All `ser_*` outputs are registered. `ser_val` is high exactly one cycle after each `bit_en` cycle that emits a bit, and is 0 otherwise (`ser_out`=0 when `ser_val`=0).
- With `bit_en` held high, bits emit back-to-back, one per clock, with no gap at SYNC/PID/payload or word boundaries.
- The final bit of the packet drives `ser_last`=1 and `ser_busy`=0 on the same output cycle. `pkt_ready`=1 on the next cycle.
- The queue accepts pushes in every state, including IDLE ahead of `pkt_start`.

## Configuration
- `USB_TX_BITSTUFF_EN` defined:
  - A ones counter runs over the PID and payload bits (SYNC excluded; it resets at the start of PID).
  - After six consecutive 1s, the next `bit_en` emits a 0 with `ser_stuff`=1, without advancing the data. The counter then resets.
  - If the stuff is due after the final data bit, the stuffed bit carries `ser_last` instead.
- Undefined: no stuffing; `ser_stuff` is tied 0.

## Test plan
- ACK: `pkt_pid`=4'b0010, `has_data`=0, `bit_en`=1 → 16 `ser_val` pulses, bits 0,0,0,0,0,0,0,1, 0,1,0,0,1,0,1,1; `ser_last` on the 16th pulse; `pkt_ready`=1 one cycle later.
- DATA0: `pid`=4'b0011, preload 8'hA5, 8'h3C(last) → 32 pulses; payload bits 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0; queue empty at the end.
- Stuffing: DATA1 `pid`=4'b1011, payload 8'hFF(last) → with macro, 25 pulses, `ser_stuff` on pulse 23, `ser_last` on pulse 25; without macro, 24 pulses.
- Underrun: `pid`=4'b0011, `has_data`=1, queue empty → 16 pulses; `ser_underrun` pulse at the 17th `bit_en`; no `ser_last`; `ser_busy`=0.
- Throttle/backpressure: `bit_en` every 4th cycle → `ser_val` spacing is exactly 4 cycles. Push 4 words with no packet → `s_ready`=0 and a 5th push is rejected.
- Reset: assert `rst_n`=0 mid-payload → outputs 0, `s_ready`=1, `pkt_ready`=1 immediately. After release, a new ACK transmits cleanly.
